// File: rtl/mw_wb_pipe_if.sv
// mw_wb_pipe_if: MEM/WB bundle bus carrying the input handshake, output handshake and flush
interface mw_wb_pipe_if #(
  parameter int LANES = 2,
  parameter int DATA_W = 32,
  parameter int REG_W = 5
);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [LANES-1:0] in_lane_valid;
  logic [LANES-1:0] in_memtoreg;
  logic [LANES-1:0] in_regwrite;
  logic [LANES*DATA_W-1:0] in_alu_result;
  logic [LANES*DATA_W-1:0] in_read_data;
  logic [LANES*REG_W-1:0] in_write_reg;
  logic out_valid;
  logic out_ready;
  logic [LANES-1:0] out_lane_valid;
  logic [LANES-1:0] out_regwrite;
  logic [LANES*REG_W-1:0] out_write_reg;
  logic [LANES*DATA_W-1:0] out_wb_data;
  logic [1:0] occupancy;
  modport master (
    output flush, in_valid, in_lane_valid, in_memtoreg, in_regwrite, in_alu_result,
           in_read_data, in_write_reg, out_ready,
    input  in_ready, out_valid, out_lane_valid, out_regwrite, out_write_reg, out_wb_data,
           occupancy
  );
  modport slave (
    input  flush, in_valid, in_lane_valid, in_memtoreg, in_regwrite, in_alu_result,
           in_read_data, in_write_reg, out_ready,
    output in_ready, out_valid, out_lane_valid, out_regwrite, out_write_reg, out_wb_data,
           occupancy
  );
endinterface

// File: rtl/mw_wb_pipe.sv
// mw_wb_pipe: multi-lane MEM/WB stage with valid/ready, flush and optional skid buffer (MW_WB_SKID_EN)
module mw_wb_pipe #(
  parameter int LANES = 2,
  parameter int DATA_W = 32,
  parameter int REG_W = 5
) (
  input logic clk,
  input logic reset_n,
  mw_wb_pipe_if.slave bus
);
  logic [LANES-1:0] c_rw, m_lv, m_rw, s_lv, s_rw;
  logic [LANES*DATA_W-1:0] c_wd, m_wd, s_wd;
  logic [LANES*REG_W-1:0] m_wr, s_wr;
  logic m_valid, s_valid, accept, drain, ld_new, ld_skid;
  always_comb begin
    c_wd = '0;
    c_rw = '0;
    for (int i = 0; i < LANES; i++) begin
      c_wd[i*DATA_W +: DATA_W] = bus.in_memtoreg[i] ? bus.in_read_data[i*DATA_W +: DATA_W]
                                                    : bus.in_alu_result[i*DATA_W +: DATA_W];
      c_rw[i] = bus.in_regwrite[i] & bus.in_lane_valid[i] & |bus.in_write_reg[i*REG_W +: REG_W];
      for (int j = i + 1; j < LANES; j++)
        c_rw[i] = (bus.in_lane_valid[j] & bus.in_regwrite[j] &
                   (bus.in_write_reg[j*REG_W +: REG_W] == bus.in_write_reg[i*REG_W +: REG_W]))
                  ? 1'b0 : c_rw[i];
    end
  end
  assign drain = m_valid && bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready && !bus.flush;
  assign ld_new = accept && (!m_valid || drain);
`ifdef MW_WB_SKID_EN
  logic rdy_q, sk_load;
  assign bus.in_ready = rdy_q;
  assign ld_skid = s_valid && drain;
  assign sk_load = accept && m_valid && !drain;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rdy_q <= 1'b1;
      s_valid <= 1'b0;
      s_lv <= '0;
      s_rw <= '0;
      s_wr <= '0;
      s_wd <= '0;
    end else if (bus.flush) begin
      rdy_q <= 1'b1;
      s_valid <= 1'b0;
    end else begin
      rdy_q <= !(sk_load || (s_valid && !drain));
      s_valid <= sk_load || (s_valid && !drain);
      if (sk_load) begin
        s_lv <= bus.in_lane_valid;
        s_rw <= c_rw;
        s_wr <= bus.in_write_reg;
        s_wd <= c_wd;
      end
    end
`else
  assign bus.in_ready = !m_valid || bus.out_ready;
  assign ld_skid = 1'b0;
  assign s_valid = 1'b0;
  assign s_lv = '0;
  assign s_rw = '0;
  assign s_wr = '0;
  assign s_wd = '0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m_valid <= 1'b0;
      m_lv <= '0;
      m_rw <= '0;
      m_wr <= '0;
      m_wd <= '0;
    end else if (bus.flush) begin
      m_valid <= 1'b0;
    end else begin
      m_valid <= ld_new || ld_skid || (m_valid && !drain);
      if (ld_new || ld_skid) begin
        m_lv <= ld_skid ? s_lv : bus.in_lane_valid;
        m_rw <= ld_skid ? s_rw : c_rw;
        m_wr <= ld_skid ? s_wr : bus.in_write_reg;
        m_wd <= ld_skid ? s_wd : c_wd;
      end
    end
  assign bus.out_valid = m_valid;
  assign bus.out_lane_valid = m_lv;
  assign bus.out_regwrite = m_rw & {LANES{m_valid}};
  assign bus.out_write_reg = m_wr;
  assign bus.out_wb_data = m_wd;
  assign bus.occupancy = {s_valid, m_valid & ~s_valid};
endmodule
